// File: rtl/spi_pkg.sv
// Shared SPI definitions: receive FSM states, default word width and a
// saturating byte-counter helper used by the SPI master/receiver pair.
package spi_pkg;

    localparam int unsigned SPI_DATA_WIDTH = 8;
    localparam int unsigned SPI_BCNT_W     = 8;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        SHIFT  = 2'd2
    } spi_state_e;

    function automatic logic [SPI_BCNT_W-1:0] sat_inc8(input logic [SPI_BCNT_W-1:0] v);
        return (v == {SPI_BCNT_W{1'b1}}) ? v : v + SPI_BCNT_W'(1);
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous receive FIFO with wrap-bit pointers, a registered non-empty flag
// and a one-cycle overrun pulse when a push is dropped.
module spi_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_c,
    output logic                  not_empty_o,
    output logic                  overrun_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  not_empty_q;
    logic                  overrun_q;
    logic                  empty_c, full_c, do_push_c, do_pop_c, drop_c;

    // Full and empty share the index bits and differ only in the wrap bit.
    always_comb begin
        empty_c   = (wr_ptr_q == rd_ptr_q);
        full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop_c  = pop_i && !empty_c;
        do_push_c = push_i && (!full_c || do_pop_c);
        drop_c    = push_i && !do_push_c;
        wr_ptr_d  = wr_ptr_q + PW'(do_push_c);
        rd_ptr_d  = rd_ptr_q + PW'(do_pop_c);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            not_empty_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            not_empty_q <= (wr_ptr_d != rd_ptr_d);
            overrun_q   <= drop_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign head_data_c = mem_q[rd_ptr_q[AW-1:0]];
    assign not_empty_o = not_empty_q;
    assign overrun_o   = overrun_q;

endmodule

// File: rtl/spi_rx_deserializer.sv
// Mode-0 SPI receiver: synchronizes sclk/MOSI/CS, shifts MSB-first words and
// hands completed words to a valid/ready stream through a small FIFO.
module spi_rx_deserializer
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  sclk,
    input  logic                  MOSI,
    input  logic                  CS,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  frame_active_o,
    output logic [SPI_BCNT_W-1:0] byte_cnt_o,
    output logic                  overrun_o,
    output logic                  frame_err_o
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   sclk_rise_c, cs_fall_c, cs_rise_c;

    spi_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SPI_BCNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic                   push_q, push_d;
    logic                   frame_err_q, frame_err_d;
    logic                   frame_active_q, frame_active_d;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise_c = sclk_s & ~sclk_prev_q;
    assign cs_fall_c   = ~cs_s & cs_prev_q;
    assign cs_rise_c   = cs_s & ~cs_prev_q;

    // Frame FSM; cs_rise wins over a coincident sclk_rise.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            RESYNC: begin
                if (cs_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall_c) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (cs_rise_c) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                end else if (sclk_rise_c) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        push_d     = 1'b1;
                        bit_cnt_d  = '0;
                        byte_cnt_d = sat_inc8(byte_cnt_q);
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = RESYNC;
        endcase
        frame_active_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sclk_sync_q    <= '0;
            mosi_sync_q    <= '0;
            cs_sync_q      <= '0;
            sclk_prev_q    <= 1'b0;
            cs_prev_q      <= 1'b0;
            state_q        <= RESYNC;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            byte_cnt_q     <= '0;
            push_q         <= 1'b0;
            frame_err_q    <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            sclk_sync_q    <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q    <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            cs_sync_q      <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            sclk_prev_q    <= sclk_s;
            cs_prev_q      <= cs_s;
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            push_q         <= push_d;
            frame_err_q    <= frame_err_d;
            frame_active_q <= frame_active_d;
        end
    end

    // shift_q holds the completed word for the cycle push_q is high.
    spi_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .push_i      (push_q),
        .push_data_i (shift_q),
        .pop_i       (rx_ready_i),
        .head_data_c (rx_data_o),
        .not_empty_o (rx_valid_o),
        .overrun_o   (overrun_o)
    );

    assign frame_active_o = frame_active_q;
    assign byte_cnt_o     = byte_cnt_q;
    assign frame_err_o    = frame_err_q;

endmodule

// File: doc/spi_rx_deserializer.md
# spi_rx_deserializer

Receive-side counterpart of `spi_master`, consuming its `sclk`/`MOSI`/`CS` outputs. It oversamples the SPI lines in the `clk_i` domain and deserializes MSB-first words. It presents each word on a valid/ready stream through a small FIFO. Used in loopback verification of `spi_master` and as the peripheral-side capture stage in SoC integration.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per word, same value as the paired `spi_master`.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: synchronizer flops on `sclk`, `MOSI` and `CS`; ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: system clock; `sclk` must toggle no faster than `clk_i`/4.
- `rstn_i` in 1: asynchronous active-low reset.
- `sclk` in 1: SPI clock, idle low (mode 0).
- `MOSI` in 1: serial data, sampled on `sclk` rising edge.
- `CS` in 1: active-low chip select.
- `rx_data_o` out DATA_WIDTH: FIFO head word.
- `rx_valid_o` out 1: FIFO non-empty.
- `rx_ready_i` in 1: consumer pops the head when `rx_valid_o && rx_ready_i`.
- `frame_active_o` out 1: high while in SHIFT.
- `byte_cnt_o` out 8: words completed in current/last frame, saturating at 255.
- `overrun_o` out 1: one-cycle pulse, word dropped because the FIFO was full.
- `frame_err_o` out 1: one-cycle pulse, `CS` deasserted with a partial word.

## Operation
- All three inputs pass through SYNC_STAGES flops. `sclk_rise` = synced sclk is 1 now and was 0 one cycle earlier. `cs_fall` and `cs_rise` are derived the same way.
- FSM states:
  - RESYNC (reset state): go to IDLE when synced CS = 1. This prevents capturing a frame already in progress when reset releases.
  - IDLE: on `cs_fall`, go to SHIFT, clear `bit_cnt` and `byte_cnt_o`.
  - SHIFT:
    - On `sclk_rise`: `shift <= {shift[DATA_WIDTH-2:0], MOSI_s}` and `bit_cnt++`.
    - When `bit_cnt` reaches DATA_WIDTH-1 on that same rise, emit a push of the completed word, wrap `bit_cnt` to 0, and increment `byte_cnt_o` (saturating).
    - On `cs_rise`: go to IDLE. If `bit_cnt` ≠ 0, pulse `frame_err_o` and discard the partial word.
- An `sclk_rise` in the same cycle as `cs_rise` is ignored; `cs_rise` takes priority.
- `sclk`/`MOSI` activity is ignored in RESYNC and IDLE.
- FIFO behaviour:
  - A push while full drops the new word and pulses `overrun_o`. Stored data is unchanged.
  - A push and a pop in the same cycle while full are both accepted, and `overrun_o` stays low.
  - A pop while empty is ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full and empty are distinguished by the MSB.
- `rx_data_o` shows the head entry combinationally from FIFO storage. Its value is don't-care while `rx_valid_o` = 0.

## Timing
- All outputs reset to 0. The FIFO resets to empty, `shift` and `bit_cnt` to 0, and the FSM to RESYNC.
- Latency:
  - Raw `sclk` rising edge to shift-register update: SYNC_STAGES+1 clocks.
  - Final bit's edge to FIFO write: same cycle as that shift.
  - `rx_valid_o` rises 1 clock after the write (SYNC_STAGES+2 from the edge).
- Throughput: one word per DATA_WIDTH `sclk` periods. Back-to-back words inside one frame need no gap.
- `frame_active_o` rises the cycle after `cs_fall` is detected and falls the cycle after `cs_rise`.
- `frame_err_o` and `overrun_o` pulse for exactly one cycle, registered.
- Reset mid-frame: all state clears immediately (async). After `rstn_i` releases, the block waits in RESYNC until CS is high.

## Structure
- Shared package `spi_pkg`: FSM state enum (RESYNC, IDLE, SHIFT) and the default DATA_WIDTH constant, shared with `spi_master`.
- One sub-module, `spi_rx_fifo`: synchronous FIFO with `DATA_WIDTH`/`FIFO_DEPTH` parameters, push/pop/full/empty, asynchronous active-low reset.
- Synchronizers and edge detection stay in the top module.

## Test plan
- Loopback with `spi_master`: transmit 0xAA then 0xCC with `rx_ready_i`=1. Expect `rx_data_o` 0xAA then 0xCC, one `rx_valid_o` cycle each, and `byte_cnt_o`=1 after each frame.
- Multi-word frame: CS held low for 0x01, 0x02, 0x03. Expect three words in order, `byte_cnt_o`=3, and `frame_err_o` never asserted.
- Backpressure: `rx_ready_i`=0, send 5 words 0x10–0x14 with FIFO_DEPTH=4. Expect exactly one `overrun_o` pulse on the 5th word. Then raise ready; expect pops of 0x10–0x13 and 0x14 absent.
- Full plus simultaneous pop: with the FIFO full, pop in the same cycle as the 5th push. Expect no overrun, and 0x14 delivered last.
- Truncated frame: CS rises after 3 bits. Expect one `frame_err_o` pulse, no FIFO write, and the next full word 0x5A received correctly.
- Reset mid-frame: assert `rstn_i` after 4 bits and release with CS still low. Expect all outputs 0 and nothing captured until CS goes high and falls again; the following word 0xC3 is then received.
